// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the LSU memory master:
//   - AluControl_reg operation codes (byte/half/word, signed and unsigned loads)
//   - FSM state encoding
//   - fault codes reported on lsu_fault
//   - check_cmd(): classifies a command as ok / misaligned / illegal
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [3:0] OP_B  = 4'b1000;
    localparam logic [3:0] OP_H  = 4'b1001;
    localparam logic [3:0] OP_W  = 4'b1010;
    localparam logic [3:0] OP_BU = 4'b1100;
    localparam logic [3:0] OP_HU = 4'b1101;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_t;

    // Illegal is checked first so that an illegal and misaligned command
    // reports illegal.
    function automatic logic [1:0] check_cmd(input logic [3:0] op,
                                             input logic       store,
                                             input logic [1:0] off);
        logic legal;
        logic misal;
        legal = 1'b0;
        misal = 1'b0;
        case (op)
            OP_B:  begin legal = 1'b1;   misal = 1'b0;         end
            OP_BU: begin legal = !store; misal = 1'b0;         end
            OP_H:  begin legal = 1'b1;   misal = off[0];       end
            OP_HU: begin legal = !store; misal = off[0];       end
            OP_W:  begin legal = 1'b1;   misal = (off != 2'b00); end
            default: begin legal = 1'b0; misal = 1'b0;         end
        endcase
        if (!legal)
            return FAULT_ILLEGAL;
        else if (misal)
            return FAULT_MISALIGN;
        else
            return FAULT_OK;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_master_if
// Word-memory request/acknowledge bus between the LSU (master) and a
// variable-latency memory (slave).
//   mem_req   master->slave  request, held until ack
//   mem_we    master->slave  write request
//   mem_addr  master->slave  word-aligned byte address
//   mem_be    master->slave  byte enables
//   mem_wdata master->slave  lane-replicated write data
//   mem_rdata slave->master  read word, valid in the ack cycle
//   mem_ack   slave->master  completes the access when seen with mem_req
// -----------------------------------------------------------------------------
interface lsu_mem_master_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align (combinational)
// Maps an operation and byte offset onto the 32-bit memory word.
//   i_op     operation code (lsu_pkg OP_*)
//   i_off    byte offset within the word (addr[1:0])
//   i_wdata  store data, low byte/half/word used
//   i_rdata  read word from memory
//   o_be     byte enables (0 for unknown ops)
//   o_wdata  store data replicated across all lanes
//   o_rdata  selected byte/half/word, sign- or zero-extended
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Bring the addressed lane down to bit 0 before extension.
    assign w_shifted = i_rdata >> {i_off, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        o_rdata = 32'h0;
        case (i_op)
            OP_B: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            OP_BU: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {24'h0, w_byte};
            end
            OP_H: begin
                o_be    = 4'b0011 << i_off;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_half[15]}}, w_half};
            end
            OP_HU: begin
                o_be    = 4'b0011 << i_off;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {16'h0, w_half};
            end
            OP_W: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = 32'h0;
                o_rdata = 32'h0;
            end
        endcase
    end
endmodule

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Initiator side of the data-memory interface. Takes one load/store command,
// checks it, runs a req/ack handshake and returns the extended load result
// together with a fault code.
//
// Parameters
//   ADDR_W          byte-address width
//   TIMEOUT_CYCLES  REQ cycles without ack before a timeout fault
//                   (only with LSU_TIMEOUT_EN)
// Ports
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   lsu_start       command strobe, sampled only in IDLE
//   lsu_store       1 = store, 0 = load
//   AluControl_reg  operation code (lsu_pkg OP_*)
//   lsu_addr        byte address
//   lsu_wdata       store data
//   lsu_busy        high in every state except IDLE
//   lsu_done        one-cycle completion pulse
//   lsu_rdata       extended load result, held until the next load completes
//   lsu_fault       00 ok, 01 misaligned, 10 illegal, 11 timeout
//   mem             master modport of lsu_mem_master_if
//
// Build option
//   LSU_TIMEOUT_EN  when defined, a REQ cycle counter aborts an access that
//                   is not acked within TIMEOUT_CYCLES cycles (fault 11).
// -----------------------------------------------------------------------------
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lsu_start,
    input  logic              lsu_store,
    input  logic [3:0]        AluControl_reg,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    output logic [1:0]        lsu_fault,
    lsu_mem_master_if.master  mem
);
    lsu_state_t        r_state;
    lsu_state_t        w_state_next;
    logic [3:0]        r_op;
    logic              r_store;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [1:0]        r_fault;

    logic [1:0]        w_cmd_fault;
    logic              w_in_req;
    logic              w_timeout;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata_ext;

    assign w_cmd_fault = check_cmd(AluControl_reg, lsu_store, lsu_addr[1:0]);
    assign w_in_req    = (r_state == ST_REQ);

    lsu_lane_align u_lane_align (
        .i_op    (r_op),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (mem.mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rdata (w_rdata_ext)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // The counter sits at zero outside REQ, so it is already clear on entry
    // and holds the number of REQ cycles already spent without ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (!w_in_req)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    // Fires in the last permitted REQ cycle so mem_req is high for exactly
    // TIMEOUT_CYCLES cycles.
    assign w_timeout = w_in_req && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register and datapath latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= 4'h0;
            r_store <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_fault <= FAULT_OK;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && lsu_start) begin
                r_op    <= AluControl_reg;
                r_store <= lsu_store;
                r_addr  <= lsu_addr;
                r_wdata <= lsu_wdata;
                r_fault <= w_cmd_fault;
            end
            if (w_in_req && mem.mem_ack) begin
                if (!r_store)
                    r_rdata <= w_rdata_ext;
            end else if (w_timeout) begin
                // An ack in the same cycle takes the branch above instead.
                r_fault <= FAULT_TIMEOUT;
            end
        end
    end

    // Next state and outputs. Bus outputs are zero outside REQ.
    always_comb begin
        w_state_next  = r_state;
        lsu_busy      = 1'b1;
        lsu_done      = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_be    = 4'b0000;
        mem.mem_wdata = 32'h0;
        case (r_state)
            ST_IDLE: begin
                lsu_busy = 1'b0;
                if (lsu_start)
                    w_state_next = (w_cmd_fault != FAULT_OK) ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = r_store;
                mem.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
                mem.mem_be    = w_be;
                mem.mem_wdata = w_wdata;
                if (mem.mem_ack || w_timeout)
                    w_state_next = ST_DONE;
            end
            ST_DONE: begin
                lsu_done     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign lsu_rdata = r_rdata;
    assign lsu_fault = r_fault;

endmodule
